// File: rtl/skinny_masked_pkg.sv
// Shared types and constants for the 2-share masked SKINNY-128-384+ datapath.
// Holds the SubCells FSM encoding, counter widths and the S-box bit-permutation helpers.
package skinny_masked_pkg;

  localparam int NUM_BYTES    = 16;
  localparam int SBOX_LAT_MAX = 15;
  localparam int CNT_W        = $clog2(SBOX_LAT_MAX + 1);
  localparam int IDX_W        = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } subcells_state_t;

  // Bit permutation applied between the nonlinear layers of the 8-bit S-box.
  function automatic logic [7:0] sbox_perm8(input logic [7:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  // Final swap of bits 1 and 2 after the last nonlinear layer.
  function automatic logic [7:0] sbox_swap8(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

endpackage

// File: rtl/skinny_sbox8_isw1_non_pipelined.sv
// First-order ISW-masked SKINNY 8-bit S-box, two Boolean shares, registered outputs.
// Each of the 8 masked NOR gates consumes one fresh bit of r; inputs must be held stable.
module skinny_sbox8_isw1_non_pipelined
  import skinny_masked_pkg::*;
(
  output logic [7:0] so1,
  output logic [7:0] so0,
  input  logic [7:0] si1,
  input  logic [7:0] si0,
  input  logic [7:0] r,
  input  logic       clk
);

  // ~(a|b) = ~a & ~b; complementing share 0 complements the shared value.
  function automatic logic [1:0] isw_nor(input logic a0, input logic a1,
                                         input logic b0, input logic b1,
                                         input logic rr);
    logic x0;
    logic y0;
    x0 = ~a0;
    y0 = ~b0;
    return {(a1 & b1) ^ ((rr ^ (x0 & b1)) ^ (a1 & y0)), (x0 & y0) ^ rr};
  endfunction

  function automatic logic [15:0] masked_mix(input logic [7:0] a0, input logic [7:0] a1,
                                             input logic [1:0] rr);
    logic [1:0] lo;
    logic [1:0] hi;
    logic [7:0] b0;
    logic [7:0] b1;
    lo = isw_nor(a0[2], a1[2], a0[3], a1[3], rr[0]);
    hi = isw_nor(a0[6], a1[6], a0[7], a1[7], rr[1]);
    b0 = a0;
    b1 = a1;
    b0[0] = a0[0] ^ lo[0];
    b1[0] = a1[0] ^ lo[1];
    b0[4] = a0[4] ^ hi[0];
    b1[4] = a1[4] ^ hi[1];
    return {b1, b0};
  endfunction

  logic [15:0] w_st1;
  logic [15:0] w_st2;
  logic [15:0] w_st3;
  logic [15:0] w_st4;

  assign w_st1 = masked_mix(si0, si1, r[1:0]);
  assign w_st2 = masked_mix(sbox_perm8(w_st1[7:0]), sbox_perm8(w_st1[15:8]), r[3:2]);
  assign w_st3 = masked_mix(sbox_perm8(w_st2[7:0]), sbox_perm8(w_st2[15:8]), r[5:4]);
  assign w_st4 = masked_mix(sbox_perm8(w_st3[7:0]), sbox_perm8(w_st3[15:8]), r[7:6]);

  always_ff @(posedge clk) begin
    so0 <= sbox_swap8(w_st4[7:0]);
    so1 <= sbox_swap8(w_st4[15:8]);
  end

endmodule

// File: rtl/skinny_subcells_isw1_serial.sv
// Serial masked SubCells: 16 bytes, MSB first, through one ISW-1 S-box.
// Optional randomness handshake (rnd_vld) enabled by SKINNY_SUBCELLS_RND_HS_EN.
//
// state | meaning
// IDLE  | waiting for start; shares latched on acceptance
// FETCH | sample rnd for the next byte (stalls on rnd_vld=0 with handshake)
// EVAL  | hold S-box drive for SBOX_LAT cycles, then collect its outputs
// DONE  | one-cycle done pulse, y0/y1 hold the new result
module skinny_subcells_isw1_serial
  import skinny_masked_pkg::*;
#(
  parameter int SBOX_LAT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] s0,
  input  logic [127:0] s1,
  input  logic [7:0]   rnd,
`ifdef SKINNY_SUBCELLS_RND_HS_EN
  input  logic         rnd_vld,
`endif
  output logic         rnd_rd,
  output logic         busy,
  output logic         done,
  output logic [127:0] y0,
  output logic [127:0] y1
);

  localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(SBOX_LAT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BYTES - 1);

  subcells_state_t r_state;
  subcells_state_t w_state_nxt;

  logic [127:0]     r_sh0;
  logic [127:0]     r_sh1;
  logic [127:0]     r_res0;
  logic [127:0]     r_res1;
  logic [127:0]     r_y0;
  logic [127:0]     r_y1;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_rnd;
  logic [7:0]       r_si0;
  logic [7:0]       r_si1;
  logic [7:0]       w_so0;
  logic [7:0]       w_so1;
  logic             w_rnd_ok;
  logic             w_eval_end;
  logic             w_last;

`ifdef SKINNY_SUBCELLS_RND_HS_EN
  assign w_rnd_ok = rnd_vld;
`else
  assign w_rnd_ok = 1'b1;
`endif

  assign w_eval_end = (r_state == ST_EVAL) && (r_cnt == LAT_M1);
  assign w_last     = (r_idx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start)      w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_rnd_ok)   w_state_nxt = ST_EVAL;
      ST_EVAL:  if (w_eval_end) w_state_nxt = w_last ? ST_DONE : ST_FETCH;
      ST_DONE:                  w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rnd_rd = (r_state == ST_FETCH) && w_rnd_ok;
    busy   = (r_state == ST_FETCH) || (r_state == ST_EVAL);
    done   = (r_state == ST_DONE);
  end

  // y0/y1 are loaded on the edge into DONE so they are valid with the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh0  <= '0;
      r_sh1  <= '0;
      r_res0 <= '0;
      r_res1 <= '0;
      r_y0   <= '0;
      r_y1   <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_rnd  <= '0;
      r_si0  <= '0;
      r_si1  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_sh0 <= s0;
        r_sh1 <= s1;
        r_idx <= IDX_LAST;
      end
      if (rnd_rd) begin
        r_rnd <= rnd;
        r_si0 <= r_sh0[127:120];
        r_si1 <= r_sh1[127:120];
        r_cnt <= '0;
      end else if (r_state == ST_EVAL) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_eval_end) begin
        r_res0 <= {r_res0[119:0], w_so0};
        r_res1 <= {r_res1[119:0], w_so1};
        r_sh0  <= {r_sh0[119:0], 8'h00};
        r_sh1  <= {r_sh1[119:0], 8'h00};
        if (w_last) begin
          r_y0 <= {r_res0[119:0], w_so0};
          r_y1 <= {r_res1[119:0], w_so1};
        end else begin
          r_idx <= r_idx - 1'b1;
        end
      end
    end
  end

  assign y0 = r_y0;
  assign y1 = r_y1;

  skinny_sbox8_isw1_non_pipelined u_sbox (
    .so1 (w_so1),
    .so0 (w_so0),
    .si1 (r_si1),
    .si0 (r_si0),
    .r   (r_rnd),
    .clk (clk)
  );

endmodule

// File: tb/tb_skinny_subcells_isw1_serial.sv
// Directed bench for skinny_subcells_isw1_serial: vector table plus multi-cycle corner cases.
// Stall scenario is built only when SKINNY_SUBCELLS_RND_HS_EN is defined.
module tb_skinny_subcells_isw1_serial;

  localparam int SBOX_LAT = 8;
  localparam int LAT_OP   = 16 * (SBOX_LAT + 1) + 1;

  typedef struct {
    logic [127:0] s0;
    logic [127:0] s1;
    logic [7:0]   rnd;
    logic [127:0] exp;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] s0;
  logic [127:0] s1;
  logic [7:0]   rnd;
`ifdef SKINNY_SUBCELLS_RND_HS_EN
  logic         rnd_vld;
`endif
  logic         rnd_rd;
  logic         busy;
  logic         done;
  logic [127:0] y0;
  logic [127:0] y1;

  int n_chk;
  int n_err;
  int cyc;

  skinny_subcells_isw1_serial #(.SBOX_LAT(SBOX_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .s0      (s0),
    .s1      (s1),
    .rnd     (rnd),
`ifdef SKINNY_SUBCELLS_RND_HS_EN
    .rnd_vld (rnd_vld),
`endif
    .rnd_rd  (rnd_rd),
    .busy    (busy),
    .done    (done),
    .y0      (y0),
    .y1      (y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts from an IDLE cycle; returns at the done cycle (or after a cycle budget).
  task automatic run_op(input logic [127:0] a0, input logic [127:0] a1, input logic [7:0] rseed,
                        input bit hold, input int stall_at, input int stall_len,
                        input bit chk_hold, input logic [127:0] h0, input logic [127:0] h1,
                        output int lat, output int nrd, output int nbad_sp,
                        output int nrd_stall, output int nhold_bad,
                        output logic [127:0] o0, output logic [127:0] o1);
    int n;
    int prev;
    bit seen;
    n = 0; prev = 0; seen = 0;
    lat = -1; nrd = 0; nbad_sp = 0; nrd_stall = 0; nhold_bad = 0;
    o0 = '0; o1 = '0;
    s0 = a0; s1 = a1; rnd = rseed; start = 1'b1;
    @(posedge clk);
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (!hold) start = 1'b0;
      rnd = rnd + 8'h3B;
`ifdef SKINNY_SUBCELLS_RND_HS_EN
      rnd_vld = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
`endif
      #1;
      if (rnd_rd) begin
        if (nrd > 0 && (n - prev) != SBOX_LAT + 1) nbad_sp++;
        prev = n;
        nrd++;
`ifdef SKINNY_SUBCELLS_RND_HS_EN
        if (!rnd_vld) nrd_stall++;
`endif
      end
      if (chk_hold && !done && (y0 !== h0 || y1 !== h1)) nhold_bad++;
      if (done) begin
        seen = 1'b1;
        lat  = n;
        o0   = y0;
        o1   = y1;
      end
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    vec_t         vecs[6];
    logic [127:0] m1, m2, m3, bm, bm_exp;
    logic [127:0] r0, r1, a_y0, a_y1, ry0_v1, ry0_v2;
    int lat, nrd, nbad, nstl, nhold, t_done1;

    n_chk = 0; n_err = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; s0 = '0; s1 = '0; rnd = '0;
`ifdef SKINNY_SUBCELLS_RND_HS_EN
    rnd_vld = 1'b1;
`endif

    m1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    m2 = 128'h5A5A3C3C_A5A5C3C3_0F0FF0F0_96966969;
    m3 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    bm     = {8'h00, {14{8'hFF}}, 8'h01};
    bm_exp = {8'h65, {14{8'hFF}}, 8'h4C};

    vecs[0] = '{s0: '0,                               s1: '0,  rnd: 8'h00, exp: {16{8'h65}}};
    vecs[1] = '{s0: bm ^ m1,                          s1: m1, rnd: 8'h11, exp: bm_exp};
    vecs[2] = '{s0: bm ^ m1,                          s1: m1, rnd: 8'hB8, exp: bm_exp};
    vecs[3] = '{s0: {16{8'hFF}} ^ m2,                 s1: m2, rnd: 8'h5C, exp: {16{8'hFF}}};
    vecs[4] = '{s0: {8{8'h00, 8'hFF}} ^ m2,           s1: m2, rnd: 8'h21, exp: {8{8'h65, 8'hFF}}};
    vecs[5] = '{s0: {4{8'h01, 8'h00, 8'hFF, 8'hFF}} ^ m3, s1: m3, rnd: 8'h9E,
                exp: {4{8'h4C, 8'h65, 8'hFF, 8'hFF}}};

    repeat (2) @(negedge clk);
    check("rst_rnd_rd", 128'(rnd_rd), 128'd0);
    check("rst_busy",   128'(busy),   128'd0);
    check("rst_done",   128'(done),   128'd0);
    check("rst_y0",     y0, '0);
    check("rst_y1",     y1, '0);
    rst = 1'b0;
    @(negedge clk);

    ry0_v1 = '0; ry0_v2 = '0;
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].s0, vecs[i].s1, vecs[i].rnd, 1'b0, 0, 0, 1'b0, '0, '0,
             lat, nrd, nbad, nstl, nhold, r0, r1);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(LAT_OP));
      check($sformatf("vec%0d_result", i), r0 ^ r1, vecs[i].exp);
      check($sformatf("vec%0d_rnd_rd_count", i), 128'(nrd), 128'd16);
      check($sformatf("vec%0d_rnd_rd_spacing_bad", i), 128'(nbad), 128'd0);
      if (i == 1) ry0_v1 = r0;
      if (i == 2) ry0_v2 = r0;
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse_width", i), 128'(done), 128'd0);
    end

    n_chk++;
    if (ry0_v1 === ry0_v2) begin
      n_err++;
      $display("FAIL rnd_changes_share: got y0 %h for both rnd seeds, required differing shares", ry0_v1);
    end

    // start held high through the run, including the DONE cycle
    run_op(bm ^ m2, m2, 8'h44, 1'b1, 0, 0, 1'b0, '0, '0, lat, nrd, nbad, nstl, nhold, r0, r1);
    check("hold_latency", 128'(lat), 128'(LAT_OP));
    check("hold_rnd_rd_count", 128'(nrd), 128'd16);
    check("hold_result", r0 ^ r1, bm_exp);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("hold_no_restart_busy", 128'(busy), 128'd0);
    @(negedge clk);
    check("hold_no_restart_rnd_rd", 128'(rnd_rd), 128'd0);

    // back-to-back: second start in the cycle after done
    run_op(vecs[5].s0, vecs[5].s1, 8'h07, 1'b0, 0, 0, 1'b0, '0, '0,
           lat, nrd, nbad, nstl, nhold, a_y0, a_y1);
    t_done1 = cyc;
    check("b2b_first_result", a_y0 ^ a_y1, vecs[5].exp);
    @(negedge clk);
    run_op(vecs[4].s0, vecs[4].s1, 8'hC3, 1'b0, 0, 0, 1'b1, a_y0, a_y1,
           lat, nrd, nbad, nstl, nhold, r0, r1);
    check("b2b_done_gap", 128'(cyc - t_done1), 128'(LAT_OP + 1));
    check("b2b_y_hold_bad_cycles", 128'(nhold), 128'd0);
    check("b2b_second_result", r0 ^ r1, vecs[4].exp);
    @(negedge clk);

    // reset in the middle of byte 7 EVAL
    s0 = m3; s1 = m1; start = 1'b1;
    @(posedge clk);
    repeat (77) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst_busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy_async", 128'(busy), 128'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_rnd_rd", 128'(rnd_rd), 128'd0);
    check("midrst_y0", y0, '0);
    check("midrst_y1", y1, '0);
    rst = 1'b0;
    @(negedge clk);
    run_op('0, '0, 8'h3D, 1'b0, 0, 0, 1'b0, '0, '0, lat, nrd, nbad, nstl, nhold, r0, r1);
    check("postrst_latency", 128'(lat), 128'(LAT_OP));
    check("postrst_result", r0 ^ r1, {16{8'h65}});
    @(negedge clk);

`ifdef SKINNY_SUBCELLS_RND_HS_EN
    // rnd_vld low for 5 cycles starting at the byte-3 FETCH
    run_op(bm ^ m1, m1, 8'h11, 1'b0, 12 * (SBOX_LAT + 1) + 1, 5, 1'b0, '0, '0,
           lat, nrd, nbad, nstl, nhold, r0, r1);
    check("stall_latency", 128'(lat), 128'(LAT_OP + 5));
    check("stall_result", r0 ^ r1, bm_exp);
    check("stall_rnd_rd_count", 128'(nrd), 128'd16);
    check("stall_rnd_rd_while_invalid", 128'(nstl), 128'd0);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
